// File: rtl/fifo_param_flags_pkg.sv
// Shared types and helpers for the parameterised FIFO and its interface.
package fifo_pkg;

    // Ceiling log2 used to size pointers and counters from DEPTH.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Default geometry of the DUV slot; the typedefs below match it.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 32;
    localparam int AW            = clog2(DEFAULT_DEPTH);

    // Word count needs one extra bit so that DEPTH itself is representable.
    typedef logic [AW:0]   fifo_cnt_t;
    typedef logic [AW-1:0] fifo_ptr_t;

    // Read-side presentation mode.
    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_param_flags_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int IF_AW = clog2(DEPTH);

    logic [WIDTH-1:0] DATA_IN;
    logic             WRITE;
    logic             READ;
    logic             CLR_ERR;
    logic [WIDTH-1:0] DATA_OUT;
    logic             DATA_VALID;
    logic [IF_AW:0]   USE_DW;
    logic             F_EMPTY_N;
    logic             F_FULL_N;
    logic             F_AEMPTY_N;
    logic             F_AFULL_N;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output DATA_IN, WRITE, READ, CLR_ERR,
        input  DATA_OUT, DATA_VALID, USE_DW,
        input  F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N,
        input  OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  DATA_IN, WRITE, READ, CLR_ERR,
        output DATA_OUT, DATA_VALID, USE_DW,
        output F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N,
        output OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/fifo_param_flags_mem_rf.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module fifo_mem_rf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [clog2(DEPTH)-1:0]    waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [clog2(DEPTH)-1:0]    raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_flags.sv
// Parameterised synchronous FIFO with programmable almost flags, sticky
// overflow/underflow errors and optional first-word-fall-through reads.
module fifo_param_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input logic   CLOCK,
    input logic   RESET,
    fifo_if.slave bus
);

    localparam int              PAW       = clog2(DEPTH);
    localparam fifo_mode_e      MODE      = (FWFT == 1) ? MODE_FWFT : MODE_STD;
    localparam logic [PAW:0]    DEPTH_CNT = (PAW + 1)'(DEPTH);
    localparam logic [PAW:0]    AF_CNT    = (PAW + 1)'(AF_LEVEL);
    localparam logic [PAW:0]    AE_CNT    = (PAW + 1)'(AE_LEVEL);
    localparam logic [PAW:0]    CNT_ONE   = (PAW + 1)'(1);
    localparam logic [PAW-1:0]  PTR_ONE   = PAW'(1);

    // Elaboration-time parameter sanity checks.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_param_flags: DEPTH must be a power of 2 and >= 4");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_param_flags: WIDTH must be >= 1");
    end
    if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL < DEPTH))) begin : g_bad_levels
        $error("fifo_param_flags: need 0 < AE_LEVEL < AF_LEVEL < DEPTH");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("fifo_param_flags: FWFT must be 0 or 1");
    end

    logic [PAW-1:0]   wr_ptr;
    logic [PAW-1:0]   rd_ptr;
    logic [PAW:0]     use_dw;
    logic [PAW:0]     cnt_next;
    logic             empty_n;
    logic             full_n;
    logic             aempty_n;
    logic             afull_n;
    logic             overflow_q;
    logic             underflow_q;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             rd_acc;
    logic             wr_acc;

    // Accept decisions and next count; a read frees the slot a full-time write needs.
    always_comb begin
        rd_acc   = bus.READ & empty_n;
        wr_acc   = bus.WRITE & (full_n | rd_acc);
        cnt_next = use_dw;
        if (wr_acc && !rd_acc) begin
            cnt_next = use_dw + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            cnt_next = use_dw - CNT_ONE;
        end
    end

    // Pointers, count and flags; flags come from the next count so they track USE_DW.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            use_dw   <= '0;
            empty_n  <= 1'b0;
            full_n   <= 1'b1;
            aempty_n <= 1'b0;
            afull_n  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            use_dw   <= cnt_next;
            empty_n  <= (cnt_next != '0);
            full_n   <= (cnt_next != DEPTH_CNT);
            aempty_n <= (cnt_next > AE_CNT);
            afull_n  <= (cnt_next < AF_CNT);
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.WRITE && !full_n && !rd_acc) begin
                overflow_q <= 1'b1;
            end else if (bus.CLR_ERR) begin
                overflow_q <= 1'b0;
            end
            if (bus.READ && !empty_n) begin
                underflow_q <= 1'b1;
            end else if (bus.CLR_ERR) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Registered read path used in standard mode: one cycle from accepted READ to data.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
                data_q <= rdata;
            end
        end
    end

    fifo_mem_rf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLOCK),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.DATA_IN),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.DATA_OUT   = (MODE == MODE_FWFT) ? rdata   : data_q;
    assign bus.DATA_VALID = (MODE == MODE_FWFT) ? empty_n : valid_q;
    assign bus.USE_DW     = use_dw;
    assign bus.F_EMPTY_N  = empty_n;
    assign bus.F_FULL_N   = full_n;
    assign bus.F_AEMPTY_N = aempty_n;
    assign bus.F_AFULL_N  = afull_n;
    assign bus.OVERFLOW   = overflow_q;
    assign bus.UNDERFLOW  = underflow_q;

endmodule
